// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller: emits a one-clk cpu_ce strobe that advances the CPU by one
// instruction, either at a selectable rate (RUN), from a debounced button (HALT), or not at all.
module cpu_clk_ctrl #(
    parameter logic [31:0] DIV_SLOW        = 32'd100_000_000,
    parameter logic [31:0] DIV_MID         = 32'd1_000_000,
    parameter logic [31:0] DIV_FAST        = 32'd100_000,
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic [1:0]  speed_sel,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_ce,
    output logic        running,
    output logic        bp_hit,
    output logic [31:0] ce_count
);

    typedef enum logic {HALT = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        run_s1_q, run_s1_d, run_s2_q, run_s2_d, run_prev_q, run_prev_d;
    logic        step_s1_q, step_s1_d, step_s2_q, step_s2_d;
    logic        step_db_q, step_db_d, step_db_prev_q, step_db_prev_d;
    logic [31:0] db_cnt_q, db_cnt_d;
    logic [1:0]  speed_q, speed_d;
    logic [31:0] rate_cnt_q, rate_cnt_d;
    logic        skip_bp_q, skip_bp_d;
    logic        cpu_ce_q, cpu_ce_d;
    logic        running_q, running_d;
    logic        bp_hit_q, bp_hit_d;
    logic [31:0] ce_count_q, ce_count_d;

    logic [31:0] n_m1;
    logic        run_rise, step_rise, speed_change, at_end, bp_fire;

    always_comb begin
        case (speed_sel)
            2'd0:    n_m1 = DIV_SLOW - 32'd1;
            2'd1:    n_m1 = DIV_MID - 32'd1;
            2'd2:    n_m1 = DIV_FAST - 32'd1;
            default: n_m1 = 32'd0;
        endcase
    end

    assign run_rise     = run_s2_q & ~run_prev_q;
    assign step_rise    = step_db_q & ~step_db_prev_q;
    assign speed_change = (speed_sel != speed_q);
    assign at_end       = !speed_change && (rate_cnt_q == n_m1);
    // skip_bp lets the instruction sitting on the breakpoint execute once after a resume.
    assign bp_fire      = at_end && bp_en && (pc == bp_addr) && !skip_bp_q;

    always_comb begin
        state_d        = state_q;
        run_s1_d       = run_sw;
        run_s2_d       = run_s1_q;
        run_prev_d     = run_s2_q;
        step_s1_d      = step_btn;
        step_s2_d      = step_s1_q;
        step_db_d      = step_db_q;
        step_db_prev_d = step_db_q;
        db_cnt_d       = db_cnt_q;
        speed_d        = speed_sel;
        rate_cnt_d     = rate_cnt_q;
        skip_bp_d      = skip_bp_q;
        cpu_ce_d       = 1'b0;
        running_d      = running_q;
        bp_hit_d       = bp_hit_q;

        // Count consecutive samples that disagree with the debounced level.
        if (step_s2_q != step_db_q) begin
            if (db_cnt_q == DEBOUNCE_CYCLES - 32'd1) begin
                step_db_d = step_s2_q;
                db_cnt_d  = 32'd0;
            end else begin
                db_cnt_d = db_cnt_q + 32'd1;
            end
        end else begin
            db_cnt_d = 32'd0;
        end

        case (state_q)
            HALT: begin
                rate_cnt_d = 32'd0;
                if (run_rise) begin
                    state_d   = RUN;
                    running_d = 1'b1;
                    bp_hit_d  = 1'b0;
                    skip_bp_d = 1'b1;
                end else if (step_rise && !run_s2_q) begin
                    cpu_ce_d = 1'b1;
                end
            end
            RUN: begin
                if (!run_s2_q || bp_fire) begin
                    state_d    = HALT;
                    running_d  = 1'b0;
                    rate_cnt_d = 32'd0;
                    if (bp_fire) bp_hit_d = 1'b1;
                end else if (speed_change) begin
                    rate_cnt_d = 32'd0;
                end else if (at_end) begin
                    rate_cnt_d = 32'd0;
                    cpu_ce_d   = 1'b1;
                    skip_bp_d  = 1'b0;
                end else begin
                    rate_cnt_d = rate_cnt_q + 32'd1;
                end
            end
        endcase

        ce_count_d = ce_count_q + {31'd0, cpu_ce_d};
    end

    // cpu_ce is a bare strobe: each high cycle is one instruction, there is no back-pressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= HALT;
            run_s1_q       <= 1'b0;
            run_s2_q       <= 1'b0;
            run_prev_q     <= 1'b0;
            step_s1_q      <= 1'b0;
            step_s2_q      <= 1'b0;
            step_db_q      <= 1'b0;
            step_db_prev_q <= 1'b0;
            db_cnt_q       <= 32'd0;
            speed_q        <= 2'd0;
            rate_cnt_q     <= 32'd0;
            skip_bp_q      <= 1'b0;
            cpu_ce_q       <= 1'b0;
            running_q      <= 1'b0;
            bp_hit_q       <= 1'b0;
            ce_count_q     <= 32'd0;
        end else begin
            state_q        <= state_d;
            run_s1_q       <= run_s1_d;
            run_s2_q       <= run_s2_d;
            run_prev_q     <= run_prev_d;
            step_s1_q      <= step_s1_d;
            step_s2_q      <= step_s2_d;
            step_db_q      <= step_db_d;
            step_db_prev_q <= step_db_prev_d;
            db_cnt_q       <= db_cnt_d;
            speed_q        <= speed_d;
            rate_cnt_q     <= rate_cnt_d;
            skip_bp_q      <= skip_bp_d;
            cpu_ce_q       <= cpu_ce_d;
            running_q      <= running_d;
            bp_hit_q       <= bp_hit_d;
            ce_count_q     <= ce_count_d;
        end
    end

    assign cpu_ce   = cpu_ce_q;
    assign running  = running_q;
    assign bp_hit   = bp_hit_q;
    assign ce_count = ce_count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: expected cpu_ce pulses (cycle, ce_count) are queued when stimulus
// is issued and a monitor pops one per observed pulse.
module tb_cpu_clk_ctrl;

    logic        clk = 1'b0;
    logic        reset, run_sw, step_btn, bp_en;
    logic [1:0]  speed_sel;
    logic [31:0] bp_addr;
    logic [31:0] pc_model = 32'd0;
    logic        cpu_ce, running, bp_hit;
    logic [31:0] ce_count;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          exp_total = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;

    cpu_clk_ctrl #(
        .DIV_SLOW(32'd8), .DIV_MID(32'd4), .DIV_FAST(32'd2), .DEBOUNCE_CYCLES(32'd3)
    ) dut (
        .clk(clk), .reset(reset), .run_sw(run_sw), .step_btn(step_btn),
        .speed_sel(speed_sel), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc_model),
        .cpu_ce(cpu_ce), .running(running), .bp_hit(bp_hit), .ce_count(ce_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) tick();
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic push_pulses(input int first, input int step, input int last);
        for (int t = first; t <= last; t += step) begin
            exp_total++;
            exp_q.push_back({exp_total[31:0], t[31:0]});
        end
    endtask

    // Monitor: every pulse must match the head of the queue; pc advances by 4 per pulse.
    task automatic monitor_loop;
        forever begin
            @(negedge clk);
            if (cpu_ce === 1'b1) begin
                pc_model = pc_model + 32'd4;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: cpu_ce=1 at cycle %0d, expected no pulse", cyc);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("pulse_cycle", cyc, exp_e[31:0]);
                    check("pulse_ce_count", ce_count, exp_e[63:32]);
                end
            end
        end
    endtask

    task automatic do_reset;
        check("pending_pulses", exp_q.size(), 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_total = 0;
        pc_model  = 32'd0;
        sample();
        check("rst_cpu_ce", cpu_ce, 32'd0);
        check("rst_running", running, 32'd0);
        check("rst_bp_hit", bp_hit, 32'd0);
        check("rst_ce_count", ce_count, 32'd0);
    endtask

    initial begin
        int p, s, r, q;
        reset = 1'b1; run_sw = 1'b0; step_btn = 1'b0; speed_sel = 2'd0;
        bp_en = 1'b0; bp_addr = 32'd0;
        fork
            monitor_loop();
        join_none
        tick_n(3);
        reset = 1'b0;

        // Idle in HALT: nothing moves.
        do_reset();
        tick_n(50);
        sample();
        check("idle_running", running, 32'd0);
        check("idle_bp_hit", bp_hit, 32'd0);
        check("idle_ce_count", ce_count, 32'd0);

        // RUN at speed_sel=1 (N=4): entry at p+3, pulses p+7, p+11, ... until drop is seen.
        speed_sel = 2'd1;
        do_reset();
        tick(); p = cyc; run_sw = 1'b1;
        push_pulses(p + 7, 4, p + 42);
        at_cycle(p + 2); sample();
        check("run_not_yet", running, 32'd0);
        at_cycle(p + 3); sample();
        check("run_entered", running, 32'd1);
        at_cycle(p + 40); run_sw = 1'b0;
        at_cycle(p + 50); sample();
        check("run_stopped", running, 32'd0);
        check("run_ce_count", ce_count, 32'd9);

        // Bouncy step in HALT: final 1 begins at p+2, debounced by p+7, pulse at p+8.
        do_reset();
        tick(); p = cyc; step_btn = 1'b1;
        push_pulses(p + 8, 1, p + 8);
        tick(); step_btn = 1'b0;
        tick(); step_btn = 1'b1;
        at_cycle(p + 12); sample();
        check("step_ce_count", ce_count, 32'd1);
        at_cycle(p + 32); sample();
        check("step_held_count", ce_count, 32'd1);
        check("step_running", running, 32'd0);
        step_btn = 1'b0;
        tick_n(8);

        // Breakpoint at 0xC, speed 3: pulses with pc=0,4,8 then halt.
        speed_sel = 2'd3; bp_en = 1'b1; bp_addr = 32'h0000_000C;
        do_reset();
        tick(); p = cyc; run_sw = 1'b1;
        push_pulses(p + 4, 1, p + 6);
        at_cycle(p + 7); sample();
        check("bp_running", running, 32'd0);
        check("bp_hit", bp_hit, 32'd1);
        check("bp_ce_count", ce_count, 32'd3);
        at_cycle(p + 12); sample();
        check("bp_still_halted", running, 32'd0);
        run_sw = 1'b0;
        tick_n(4);
        tick(); s = cyc; step_btn = 1'b1;
        push_pulses(s + 6, 1, s + 6);
        at_cycle(s + 10); sample();
        check("bp_step_count", ce_count, 32'd4);
        check("bp_step_pc", pc_model, 32'h0000_0010);
        check("bp_hit_after_step", bp_hit, 32'd1);
        step_btn = 1'b0;
        tick_n(8);
        tick(); r = cyc; run_sw = 1'b1;
        push_pulses(r + 4, 1, r + 7);
        at_cycle(r + 2); sample();
        check("bp_hit_before_rerun", bp_hit, 32'd1);
        at_cycle(r + 3); sample();
        check("bp_hit_cleared", bp_hit, 32'd0);
        check("bp_rerun_running", running, 32'd1);
        at_cycle(r + 5); run_sw = 1'b0;
        at_cycle(r + 12); sample();
        check("bp_rerun_count", ce_count, 32'd8);
        check("bp_rerun_stopped", running, 32'd0);

        // Resume while pc already equals bp_addr: the first instruction must still issue.
        bp_addr = 32'd0;
        do_reset();
        tick(); p = cyc; run_sw = 1'b1;
        push_pulses(p + 4, 1, p + 8);
        at_cycle(p + 6); run_sw = 1'b0;
        at_cycle(p + 12); sample();
        check("skip_bp_hit", bp_hit, 32'd0);
        check("skip_bp_count", ce_count, 32'd5);
        bp_en = 1'b0;

        // speed 0 -> 2 mid-count: counter restarts at p+7, pulses p+9, p+11, ...
        speed_sel = 2'd0;
        do_reset();
        tick(); p = cyc; run_sw = 1'b1;
        at_cycle(p + 6); speed_sel = 2'd2;
        push_pulses(p + 9, 2, p + 16);
        at_cycle(p + 14); run_sw = 1'b0;
        at_cycle(p + 22); sample();
        check("speed_ce_count", ce_count, 32'd4);

        // Reset during RUN at speed 3 kills the pending pulse; run_sw must re-rise.
        speed_sel = 2'd3;
        do_reset();
        tick(); p = cyc; run_sw = 1'b1;
        push_pulses(p + 4, 1, p + 8);
        at_cycle(p + 8); reset = 1'b1; run_sw = 1'b0;
        tick(); reset = 1'b0;
        exp_total = 0;
        pc_model  = 32'd0;
        sample();
        check("midrst_cpu_ce", cpu_ce, 32'd0);
        check("midrst_running", running, 32'd0);
        check("midrst_bp_hit", bp_hit, 32'd0);
        check("midrst_ce_count", ce_count, 32'd0);
        at_cycle(p + 20); sample();
        check("midrst_halted", running, 32'd0);
        tick(); q = cyc; run_sw = 1'b1;
        push_pulses(q + 4, 1, q + 5);
        at_cycle(q + 3); run_sw = 1'b0; sample();
        check("midrst_resumed", running, 32'd1);
        at_cycle(q + 10); sample();
        check("midrst_final_count", ce_count, 32'd2);
        check("midrst_final_running", running, 32'd0);

        check("final_pending", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
